// File: rtl/sar_adc_pkg.sv
// Shared definitions for the multi-channel SAR ADC scan controller:
// default geometry, FSM state codes, width helpers and the channel
// priority search used to walk the enabled-channel mask.
package sar_adc_pkg;

  localparam int ADC_WIDTH_DEF  = 8;
  localparam int CH_NUM_DEF     = 4;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int SETTLE_CYC_DEF = 1;

  // Upper bound on CH_NUM supported by the channel search below.
  localparam int MAX_CH = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_SETTLE = 3'd1;
  localparam state_t S_CONV   = 3'd2;
  localparam state_t S_ACC    = 3'd3;
  localparam state_t S_NEXT   = 3'd4;

  // Bits needed to hold values 0..n-1; never less than one bit so that a
  // single-channel build still has a 1-bit mux select.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: 2**avg_log2 codes of adc_w bits cannot overflow it.
  function automatic int acc_w(input int adc_w, input int avg_log2);
    return adc_w + avg_log2;
  endfunction

  // Lowest enabled channel index >= from, or -1 when none remains.
  function automatic int next_enabled(input logic [MAX_CH-1:0] mask, input int from);
    int found;
    found = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) found = i;
    end
    return found;
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// One successive-approximation conversion: i_go loads the MSB trial code,
// then each clock keeps or drops the current trial bit from the comparator
// and raises the next lower bit. o_done marks the edge that resolves the
// LSB; o_code holds the finished code from the following cycle.
module sar_bit_engine
  import sar_adc_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_go,
  input  logic                 i_clr,
  input  logic                 i_cmp,
  output logic [ADC_WIDTH-1:0] o_dac,
  output logic                 o_done,
  output logic [ADC_WIDTH-1:0] o_code
);

  localparam logic [ADC_WIDTH-1:0] MSB = ADC_WIDTH'(1) << (ADC_WIDTH - 1);

  logic [ADC_WIDTH-1:0] r_dac;
  logic [ADC_WIDTH-1:0] r_trial;
  logic                 r_act;
  logic [ADC_WIDTH-1:0] r_code;
  logic [ADC_WIDTH-1:0] w_kept;

  // Trial bit survives only when the input is at or above the DAC level.
  assign w_kept = i_cmp ? r_dac : (r_dac & ~r_trial);

  // Trial code register and one-hot pointer to the bit under test.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dac   <= '0;
      r_trial <= '0;
      r_act   <= 1'b0;
    end else if (i_go) begin
      r_dac   <= MSB;
      r_trial <= MSB;
      r_act   <= 1'b1;
    end else if (r_act) begin
      r_dac   <= w_kept | (r_trial >> 1);
      r_trial <= r_trial >> 1;
      if (r_trial[0]) r_act <= 1'b0;
    end else if (i_clr) begin
      r_dac <= '0;
    end
  end

  // Capture the resolved code on the LSB edge.
  always_ff @(posedge clk) begin
    if (r_act && r_trial[0]) r_code <= w_kept;
  end

  assign o_dac  = r_dac;
  assign o_done = r_act & r_trial[0];
  assign o_code = r_code;

endmodule

// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller. Walks the enabled channels in
// ascending order, runs 2**AVG_LOG2 settle+convert passes per channel
// through one comparator/DAC, and reports the truncated average per channel
// with den, plus eoc on the last one.
// Optional feature macro: SAR_ADC_CONT_SCAN_EN adds input cont; with cont
// high at scan end the mask is re-latched and a new scan follows directly.
module sar_adc_scan_ctrl
  import sar_adc_pkg::*;
#(
  parameter  int ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter  int CH_NUM     = CH_NUM_DEF,
  parameter  int AVG_LOG2   = AVG_LOG2_DEF,
  parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
  localparam int CH_W       = cnt_w(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CH_NUM-1:0]    ch_mask,
  input  logic                 cmp,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic [CH_W-1:0]      mux_sel,
  output logic                 sample,
  output logic                 busy,
  output logic                 den,
  output logic                 eoc,
  output logic [CH_W-1:0]      ch_id,
  output logic [ADC_WIDTH-1:0] Dout
`ifdef SAR_ADC_CONT_SCAN_EN
  ,
  input  logic                 cont
`endif
);

  localparam int ACC_W = acc_w(ADC_WIDTH, AVG_LOG2);
  localparam int ST_W  = cnt_w(SETTLE_CYC);
  localparam int NC_W  = cnt_w(2 ** AVG_LOG2);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [NC_W-1:0] NC_LAST = NC_W'((2 ** AVG_LOG2) - 1);

  state_t                r_state;
  logic [CH_NUM-1:0]     r_mask;
  logic [CH_W-1:0]       r_ch;
  logic [CH_W-1:0]       r_chid;
  logic [ST_W-1:0]       r_settle;
  logic [NC_W-1:0]       r_nconv;
  logic [ACC_W-1:0]      r_acc;
  logic [ADC_WIDTH-1:0]  r_dout;
  logic                  r_den;
  logic                  r_eoc;
  logic                  r_busy;

  logic [MAX_CH-1:0]     w_req_ext;
  logic [MAX_CH-1:0]     w_mask_ext;
  int                    w_first;
  int                    w_nxt;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_go;
  logic                  w_clr;
  logic                  w_done;
  logic                  w_rescan;
  logic [ADC_WIDTH-1:0]  w_dac;
  logic [ADC_WIDTH-1:0]  w_code;

`ifdef SAR_ADC_CONT_SCAN_EN
  assign w_rescan = cont;
`else
  assign w_rescan = 1'b0;
`endif

  // Channel search: first channel of a requested mask, and the channel
  // after the current one in the latched mask.
  always_comb begin
    w_req_ext               = '0;
    w_req_ext[CH_NUM-1:0]   = ch_mask;
    w_mask_ext              = '0;
    w_mask_ext[CH_NUM-1:0]  = r_mask;
    w_first                 = next_enabled(w_req_ext, 0);
    w_nxt                   = next_enabled(w_mask_ext, int'(r_ch) + 1);
  end

  // Kick the bit engine on the last settle cycle; park its DAC at zero
  // once the code has been accumulated so the next SETTLE sees 0.
  assign w_go  = (r_state == S_SETTLE) && (r_settle == ST_LAST);
  assign w_clr = (r_state == S_ACC);
  assign w_sum = r_acc + ACC_W'(w_code);

  sar_bit_engine #(
    .ADC_WIDTH (ADC_WIDTH)
  ) u_bit_engine (
    .clk    (clk),
    .rst    (rst),
    .i_go   (w_go),
    .i_clr  (w_clr),
    .i_cmp  (cmp),
    .o_dac  (w_dac),
    .o_done (w_done),
    .o_code (w_code)
  );

  // Scan sequencer: channel walk, averaging and result/pulse generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_ch     <= '0;
      r_chid   <= '0;
      r_settle <= '0;
      r_nconv  <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
      r_den    <= 1'b0;
      r_eoc    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_den <= 1'b0;
      r_eoc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_busy) begin
            r_mask <= ch_mask;
            if (w_first >= 0) begin
              r_ch     <= CH_W'(w_first);
              r_settle <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_SETTLE;
            end else begin
              // Empty mask: report an immediate, empty scan.
              r_eoc <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle == ST_LAST) begin
            r_settle <= '0;
            r_state  <= S_CONV;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_CONV: begin
          if (w_done) r_state <= S_ACC;
        end
        S_ACC: begin
          if (r_nconv == NC_LAST) begin
            // Result and pulses are registered here so they are visible
            // during the NEXT cycle; eoc rides with the final channel.
            r_dout  <= w_sum[ACC_W-1:AVG_LOG2];
            r_chid  <= r_ch;
            r_den   <= 1'b1;
            r_eoc   <= (w_nxt < 0);
            r_acc   <= '0;
            r_nconv <= '0;
            r_state <= S_NEXT;
          end else begin
            r_acc   <= w_sum;
            r_nconv <= r_nconv + 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_NEXT: begin
          if (w_nxt >= 0) begin
            r_ch    <= CH_W'(w_nxt);
            r_state <= S_SETTLE;
          end else if (w_rescan) begin
            r_mask <= ch_mask;
            if (w_first >= 0) begin
              r_ch    <= CH_W'(w_first);
              r_state <= S_SETTLE;
            end else begin
              r_eoc   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DACF    = w_dac;
  assign mux_sel = r_ch;
  assign sample  = (r_state == S_SETTLE);
  assign busy    = r_busy;
  assign den     = r_den;
  assign eoc     = r_eoc;
  assign ch_id   = r_chid;
  assign Dout    = r_dout;

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Scoreboard bench for sar_adc_scan_ctrl: each scan request pushes the
// expected per-channel results; a monitor pops them on every den.
module tb_sar_adc_scan_ctrl;

  localparam int W    = 8;
  localparam int CHN  = 4;
  localparam int AVG  = 2;
  localparam int SET  = 1;
  localparam int NAVG = 1 << AVG;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   ch_mask;
  logic         cmp;
  logic [W-1:0] DACF;
  logic [1:0]   mux_sel;
  logic         sample;
  logic         busy;
  logic         den;
  logic         eoc;
  logic [1:0]   ch_id;
  logic [W-1:0] Dout;

  sar_adc_scan_ctrl #(
    .ADC_WIDTH  (W),
    .CH_NUM     (CHN),
    .AVG_LOG2   (AVG),
    .SETTLE_CYC (SET)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ch_mask (ch_mask),
    .cmp     (cmp),
    .DACF    (DACF),
    .mux_sel (mux_sel),
    .sample  (sample),
    .busy    (busy),
    .den     (den),
    .eoc     (eoc),
    .ch_id   (ch_id),
    .Dout    (Dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int val;
    bit last;
  } exp_t;

  exp_t       q[$];
  int         zero_pend = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] vin [4];
  bit         alt_mode = 1'b0;
  int         alt_cnt = 0;
  logic [7:0] alt_val = 8'd100;
  logic [3:0] cur_mask = 4'b0000;

  // Analogue front end: ideal comparator against the selected input.
  assign cmp = (alt_mode && mux_sel == 2'd0) ? (alt_val >= DACF) : (vin[mux_sel] >= DACF);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Alternating source for ch0: a new value for every conversion.
  initial begin
    logic ps;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (sample === 1'b1 && ps !== 1'b1) begin
        alt_val = (alt_cnt % 2 == 1) ? 8'd103 : 8'd100;
        alt_cnt++;
      end
      ps = sample;
    end
  end

  // Monitor: compare every den/eoc against the scoreboard.
  initial begin
    exp_t e;
    bit   prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_last) check("busy_fall_after_eoc", busy, 0);
      prev_last = 1'b0;
      if (busy === 1'b1 && sample === 1'b1) check("mux_sel_enabled", cur_mask[mux_sel], 1);
      if (den === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_den: ch_id=%0d Dout=%0d, no result expected", ch_id, Dout);
        end else begin
          e = q.pop_front();
          check("den_ch_id", ch_id, e.ch);
          check("den_Dout", Dout, e.val);
          check("eoc_with_den", eoc, e.last);
          prev_last = e.last;
        end
      end else if (eoc === 1'b1) begin
        if (zero_pend > 0) begin
          zero_pend--;
          check("empty_scan_busy", busy, 0);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_eoc: eoc=1 without den, none expected");
        end
      end
    end
  end

  // Expected results for one scan, from the averaging rule.
  task automatic push_scan(input logic [3:0] m);
    exp_t e;
    int   hi;
    int   s;
    if (m == 4'b0000) begin
      zero_pend++;
    end else begin
      hi = -1;
      for (int i = 0; i < CHN; i++) if (m[i]) hi = i;
      for (int i = 0; i < CHN; i++) begin
        if (m[i]) begin
          s = 0;
          for (int k = 0; k < NAVG; k++) begin
            if (alt_mode && i == 0) s += ((alt_cnt + k) % 2 == 1) ? 103 : 100;
            else s += vin[i];
          end
          e.ch   = i;
          e.val  = s >> AVG;
          e.last = (i == hi);
          q.push_back(e);
        end
      end
    end
  endtask

  // Issue a scan and wait for busy to drop; returns cycles to first den.
  task automatic run_scan(input logic [3:0] m, input bit noise, output int lat);
    int n;
    ch_mask  = m;
    cur_mask = m;
    push_scan(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (m == 4'b0000) begin
      check("empty_scan_eoc_timing", eoc, 1);
      check("empty_scan_no_den", den, 0);
    end
    n   = 1;
    lat = -1;
    while (n <= 400) begin
      if (den === 1'b1 && lat < 0) lat = n;
      if (busy !== 1'b1) break;
      if (noise && (n % 13 == 5)) begin
        start   = 1'b1;
        ch_mask = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (n > 400) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: busy still %0d after 400 cycles, expected 0", busy);
    end
    repeat (3) tick();
  endtask

  initial begin
    int lat;
    int n;
    logic [3:0] m;
    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = 4'b0000;
    vin[0] = 8'd153; vin[1] = 8'd0; vin[2] = 8'd255; vin[3] = 8'd128;
    repeat (3) tick();
    check("rst_DACF", DACF, 0);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_sample", sample, 0);
    check("rst_busy", busy, 0);
    check("rst_den", den, 0);
    check("rst_eoc", eoc, 0);
    check("rst_ch_id", ch_id, 0);
    check("rst_Dout", Dout, 0);
    rst = 1'b0;
    tick();

    // Full scan with fixed inputs and first-result latency.
    run_scan(4'b1111, 1'b0, lat);
    check("first_den_latency", lat, (SET + W + 1) * NAVG + 1);

    // Sparse mask.
    run_scan(4'b0101, 1'b0, lat);

    // Averaging of alternating conversions on ch0.
    alt_mode = 1'b1;
    alt_cnt  = 0;
    run_scan(4'b0001, 1'b0, lat);
    alt_mode = 1'b0;

    // Start pulses and mask changes while busy are ignored.
    run_scan(4'b1111, 1'b1, lat);
    check("idle_after_noisy_scan", busy, 0);

    // Empty mask.
    run_scan(4'b0000, 1'b0, lat);

    // Reset in the middle of a ch1 conversion.
    ch_mask  = 4'b1111;
    cur_mask = 4'b1111;
    push_scan(4'b1111);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(busy === 1'b1 && mux_sel == 2'd1 && sample === 1'b0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_ch1_conv: mux_sel=%0d after 200 cycles, expected 1", mux_sel);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check("midrst_DACF", DACF, 0);
    check("midrst_mux_sel", mux_sel, 0);
    check("midrst_sample", sample, 0);
    check("midrst_busy", busy, 0);
    check("midrst_den", den, 0);
    check("midrst_eoc", eoc, 0);
    check("midrst_ch_id", ch_id, 0);
    check("midrst_Dout", Dout, 0);
    repeat (3) tick();
    check("midrst_stays_idle", busy, 0);
    run_scan(4'b1111, 1'b0, lat);
    check("post_rst_first_den_latency", lat, (SET + W + 1) * NAVG + 1);

    // Randomised inputs and masks.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < CHN; i++) vin[i] = 8'($urandom_range(0, 255));
      if (t == 0) begin
        vin[0] = 8'd0;
        vin[3] = 8'd255;
      end
      m = 4'($urandom);
      run_scan(m, (t % 3 == 0), lat);
    end

    check("scoreboard_drained", q.size(), 0);
    check("empty_eoc_drained", zero_pend, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
